// File: rtl/prod_accumulator.sv
// Accumulates N_TERMS unsigned products per frame and holds the total on a valid/ready output.
// Define ACC_SAT_EN to clamp an overflowing frame at 2^ACC_W-1 instead of wrapping.
module prod_accumulator #(
    parameter  int PROD_W  = 8,
    parameter  int ACC_W   = 12,
    parameter  int N_TERMS = 8,
    localparam int CNT_W   = $clog2(N_TERMS + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [PROD_W-1:0] prod_in,
    input  logic              prod_valid,
    output logic              prod_ready,
    input  logic              flush,
    output logic [ACC_W-1:0]  acc_out,
    output logic              acc_valid,
    input  logic              acc_ready,
    output logic              ovf,
    output logic [CNT_W-1:0]  term_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_DONE
    } state_t;

    state_t             state, state_nxt;
    logic [ACC_W-1:0]   acc, acc_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [ACC_W-1:0]   out_q, out_nxt;
    logic               vld_q, vld_nxt;
    logic               ovf_q, ovf_nxt;

    logic               xfer;
    logic               close;
    logic [ACC_W:0]     sum;
    logic               carry;
    logic [ACC_W-1:0]   add_res;

    assign xfer  = prod_valid && (state != S_DONE);
    assign sum   = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod_in};
    assign carry = sum[ACC_W];

`ifdef ACC_SAT_EN
    // Once the frame has overflowed the total is pinned at full scale until it closes.
    assign add_res = (carry || ovf_q) ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
    assign add_res = sum[ACC_W-1:0];
`endif

    // A frame closes on the transfer that completes it, or on flush once it holds a product.
    assign close = (xfer && (cnt == CNT_W'(N_TERMS - 1))) ||
                   (flush && (state == S_ACCUM));

    always_comb begin
        // NOTE: every variable gets a default before the case so no path infers a latch.
        state_nxt = state;
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        out_nxt   = out_q;
        vld_nxt   = vld_q;
        ovf_nxt   = ovf_q;
        case (state)
            S_IDLE, S_ACCUM: begin
                if (xfer) begin
                    acc_nxt   = add_res;
                    cnt_nxt   = cnt + CNT_W'(1);
                    ovf_nxt   = ovf_q | carry;
                    state_nxt = S_ACCUM;
                end
                if (close) begin
                    out_nxt   = acc_nxt;
                    vld_nxt   = 1'b1;
                    acc_nxt   = '0;
                    cnt_nxt   = '0;
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (acc_ready) begin
                    vld_nxt   = 1'b0;
                    ovf_nxt   = 1'b0;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments; reset is synchronous and wins over all inputs.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc   <= '0;
            cnt   <= '0;
            out_q <= '0;
            vld_q <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            acc   <= acc_nxt;
            cnt   <= cnt_nxt;
            out_q <= out_nxt;
            vld_q <= vld_nxt;
            ovf_q <= ovf_nxt;
        end
    end

    assign prod_ready = (state != S_DONE);
    assign acc_out    = out_q;
    assign acc_valid  = vld_q;
    assign ovf        = ovf_q;
    assign term_cnt   = cnt;

endmodule

// File: doc/prod_accumulator.md
Name: prod_accumulator

Overview:
- Downstream consumer of the 4x4 array multiplier: takes its 8-bit unsigned products through a valid/ready handshake.
- Sums N_TERMS products into a frame total and presents the total on a held valid/ready output port.
- Forms the accumulate half of a dot-product datapath; the multiplier remains purely combinational upstream.

Parameters:
- PROD_W, 8, width of incoming product (multiplier output width).
- ACC_W, 12, accumulator/result width; default holds 8 x 225 = 1800 without overflow.
- N_TERMS, 8, products per frame; must be >= 1.
- CNT_W (localparam), $clog2(N_TERMS+1), width of term counter.

Ports:
- clk  input  1  single clock, all logic on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising clk.
- prod_in  input  PROD_W  product from multiplier, unsigned.
- prod_valid  input  1  prod_in valid.
- prod_ready  output  1  block can accept a product this cycle.
- flush  input  1  close the current partial frame early.
- acc_out  output  ACC_W  frame total.
- acc_valid  output  1  acc_out valid, held until accepted.
- acc_ready  input  1  consumer accepts acc_out.
- ovf  output  1  current/presented frame overflowed ACC_W.
- term_cnt  output  CNT_W  products accepted in the current frame.

Behaviour:
- Reset (rst_n=0 at clk edge): state IDLE, acc=0, term_cnt=0, acc_out=0, acc_valid=0, ovf=0. Reset mid-frame or mid-hold discards everything; rst_n has priority over all inputs.
- FSM states:
  - IDLE: term_cnt=0.
  - ACCUM: 0 < term_cnt < N_TERMS.
  - DONE: result held.
- prod_ready = 1 in IDLE/ACCUM, 0 in DONE (combinational from state only).
- Transfer = prod_valid & prod_ready.
  - On transfer: acc <= acc + zero-extended prod_in; term_cnt++; IDLE->ACCUM.
  - The internal sum is computed at ACC_W+1 bits; a carry out sets the frame's sticky ovf.
- Frame close occurs on either:
  - a transfer that makes term_cnt reach N_TERMS, or
  - flush=1 while in ACCUM.
- Frame close behaviour:
  - Next edge: acc_out <= final sum (including any product transferred in the same cycle), acc_valid <= 1, ovf reflects the frame, state -> DONE, acc and term_cnt cleared.
  - Latency: result visible exactly 1 cycle after the closing edge.
- N_TERMS=1: every transfer closes a frame; IDLE->DONE directly.
- flush in IDLE: ignored; empty frames are never emitted. flush in DONE: ignored.
- DONE:
  - acc_out, acc_valid and ovf are stable while acc_ready=0.
  - acc_valid & acc_ready -> next edge acc_valid=0, ovf=0, state IDLE. acc_out keeps its last value and is don't-care while acc_valid=0.
  - No product is accepted in the accept cycle, so throughput is one frame per N_TERMS+1 cycles at best.
- prod_in is ignored when prod_valid=0 or prod_ready=0.

Optional Feature:
- Macro ACC_SAT_EN.
- Defined: on overflow, acc clamps to 2^ACC_W-1 and stays clamped for the rest of the frame; ovf=1.
- Undefined: acc wraps modulo 2^ACC_W; ovf still set sticky for the frame. Port list is identical in both builds.

Test Plan:
- N_TERMS=4, four transfers of 225 back-to-back, acc_ready=1 -> one cycle after 4th accept acc_out=900, acc_valid=1, ovf=0, term_cnt=0; next cycle acc_valid=0, prod_ready=1.
- N_TERMS=4, frame {1,2,3,4}, acc_ready held low 5 cycles -> acc_out=10 stable, prod_ready=0 throughout, prod_valid pulses ignored; acc_ready=1 -> IDLE.
- N_TERMS=8, products 10,20 then flush alone -> acc_out=30; also product 5 with flush in the same cycle after 10 -> acc_out=15; flush in IDLE -> no acc_valid.
- ACC_W=10, N_TERMS=8, eight products of 225 -> without ACC_SAT_EN acc_out=776 (1800 mod 1024), ovf=1; with ACC_SAT_EN acc_out=1023, ovf=1.
- N_TERMS=4, three products of 50, then rst_n=0 for one cycle, then four products of 1 -> single result acc_out=4, ovf=0; no result emitted for the aborted frame.
- N_TERMS=1, prod_valid held high with values 7, 9 -> outputs 7 then 9, one accept every 2 cycles.
